// File: rtl/bist_pkg.sv
// Shared definitions for the BIST fail-capture path: FSM state encoding,
// default memory geometry and the fail-log entry layout.
package bist_pkg;

  localparam int BIST_ADR_SIZE  = 4;
  localparam int BIST_DATA_SIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [BIST_ADR_SIZE-1:0]  addr;
    logic [BIST_DATA_SIZE-1:0] syn;
  } log_entry_t;

endpackage

// File: rtl/bist_log_fifo.sv
// Synchronous FIFO for fail-log entries. Pointers carry a wrap bit so full
// and empty are distinguished without a separate occupancy counter.
module bist_log_fifo
  import bist_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = log_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_en;
  logic        pop_en;

  T mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot the push lands in.
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !clr) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  // Stale storage is never visible: an empty FIFO presents an all-zero head.
  always_comb begin
    head = '0;
    if (!empty) head = mem_q[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/bist_fail_log.sv
// Fail-capture stage behind the BIST compare step: counts mismatches, logs the
// first DEPTH failing locations and produces the final pass/fail verdict.
module bist_fail_log
  import bist_pkg::*;
#(
  parameter int ADR_SIZE  = BIST_ADR_SIZE,
  parameter int DATA_SIZE = BIST_DATA_SIZE,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cmp_valid,
  input  logic [ADR_SIZE-1:0]  cmp_addr,
  input  logic [DATA_SIZE-1:0] cmp_exp,
  input  logic [DATA_SIZE-1:0] cmp_act,
  input  logic                 bist_done,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ADR_SIZE-1:0]  rd_addr,
  output logic [DATA_SIZE-1:0] rd_syn,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 overflow,
  output logic                 result_valid,
  output logic                 pass
);

  typedef struct packed {
    logic [ADR_SIZE-1:0]  addr;
    logic [DATA_SIZE-1:0] syn;
  } entry_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              res_q, res_d;
  logic              pass_q, pass_d;

  logic   armed;
  logic   is_fail;
  logic   pop;
  logic   push;
  logic   drop;
  logic   fifo_full;
  logic   fifo_empty;
  entry_t push_entry;
  entry_t head_entry;

  assign armed   = (state_q == ST_ARMED);
  // A start in the same cycle wins over any compare.
  assign is_fail = armed && !start && cmp_valid && (cmp_exp != cmp_act);
  assign pop     = !fifo_empty && rd_ready;
  assign push    = is_fail;
  assign drop    = is_fail && fifo_full && !pop;

  assign push_entry.addr = cmp_addr;
  assign push_entry.syn  = cmp_exp ^ cmp_act;

  bist_log_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    pass_d  = pass_q;
    if (start) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      res_d   = 1'b0;
      pass_d  = 1'b0;
    end else begin
      if (is_fail && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
      if (drop) ovf_d = 1'b1;
      // The verdict uses the next count so a fail alongside bist_done counts.
      if (armed && bist_done) begin
        res_d   = 1'b1;
        pass_d  = (cnt_d == '0);
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      pass_q  <= pass_d;
    end
  end

  assign rd_valid     = !fifo_empty;
  assign rd_addr      = head_entry.addr;
  assign rd_syn       = head_entry.syn;
  assign fail_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign result_valid = res_q;
  assign pass         = pass_q;

endmodule
